// File: rtl/enc_pkg.sv
// Shared types and constants for the encoder homing logic.
package enc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEEK,
        HOME,
        ERR
    } home_state_t;

    localparam int IDX_CNT_W = 4;

endpackage

// File: rtl/idx_qualifier.sv
// Synchronizes the raw encoder pins and qualifies the index pulse by width.
// Kept standalone so an index-error monitor can reuse it.
module idx_qualifier
    import enc_pkg::*;
#(
    parameter int IDX_MIN = 4,
    parameter bit GATE_AB = 1'b1
) (
    input  logic sclk,
    input  logic rstn,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enc_i,
    output logic idx_q,
    output logic idx_ok
);

    localparam logic [IDX_CNT_W-1:0] CNT_MAX = IDX_CNT_W'(IDX_MIN);

    // Bit order in both stages: {a, b, i}.
    logic [2:0]           sync1_q;
    logic [2:0]           sync2_q;
    logic [IDX_CNT_W-1:0] cnt_q;
    logic [IDX_CNT_W-1:0] cnt_d;
    logic                 ab_ok;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so sync2_q takes the old sync1_q,
            // giving two real flop stages rather than one.
            sync1_q <= {enc_a, enc_b, enc_i};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign ab_ok = GATE_AB ? (sync2_q[2] & sync2_q[1]) : 1'b1;
    assign idx_q = sync2_q[0] & ab_ok;

    // cnt_d already includes the current qualifying cycle, so the first high
    // cycle of idx_q counts as 1 and idx_ok rises on the IDX_MIN-th one.
    always_comb begin
        // NOTE: default first, so every path assigns cnt_d and no latch is inferred.
        cnt_d = '0;
        if (idx_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign idx_ok = (cnt_d == CNT_MAX);

endmodule

// File: rtl/enc_home_ctrl.sv
// Homing sequencer: arms on request, waits for a qualified index pulse and
// issues a one-cycle home strobe, with abort, timeout and sticky status.
module enc_home_ctrl
    import enc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int TIMEOUT_W      = 27,
    parameter int IDX_MIN        = 4,
    parameter bit GATE_AB        = 1'b1
) (
    input  logic sclk,
    input  logic rstn,
    input  logic home_req,
    input  logic abort,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enc_i,
    output logic home,
    output logic busy,
    output logic homed,
    output logic timeout_err
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    home_state_t          state_q;
    logic [TIMEOUT_W-1:0] tmr_q;
    logic                 home_q;
    logic                 busy_q;
    logic                 homed_q;
    logic                 terr_q;
    logic                 idx_q;
    logic                 idx_ok;
    logic                 tmr_last;

    idx_qualifier #(
        .IDX_MIN (IDX_MIN),
        .GATE_AB (GATE_AB)
    ) u_idx_qualifier (
        .sclk   (sclk),
        .rstn   (rstn),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .enc_i  (enc_i),
        .idx_q  (idx_q),
        .idx_ok (idx_ok)
    );

    assign tmr_last = (tmr_q == TMO_LAST);

    // Priority in ARM/SEEK: abort, then a qualified index, then timeout.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            home_q  <= 1'b0;
            busy_q  <= 1'b0;
            homed_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            // NOTE: a later non-blocking assignment in the same block overrides
            // this default, which keeps home_q a clean single-cycle strobe.
            home_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (home_req && !abort) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                        homed_q <= 1'b0;
                        terr_q  <= 1'b0;
                        tmr_q   <= '0;
                    end
                end
                ARM: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tmr_last) begin
                        state_q <= ERR;
                        busy_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                        if (!idx_q) begin
                            state_q <= SEEK;
                        end
                    end
                end
                SEEK: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (idx_ok) begin
                        state_q <= HOME;
                        home_q  <= 1'b1;
                    end else if (tmr_last) begin
                        state_q <= ERR;
                        busy_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                HOME: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    homed_q <= 1'b1;
                end
                ERR: begin
                    state_q <= IDLE;
                    terr_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign home        = home_q;
    assign busy        = busy_q;
    assign homed       = homed_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_enc_home_ctrl.sv
// Directed bench for enc_home_ctrl: a cycle table for the basic home plus
// hand-written sequences for held index, short/gated pulses, timeout, abort and reset.
module tb_enc_home_ctrl;

    localparam int TMO = 50;

    logic sclk = 1'b0;
    logic rstn = 1'b0;
    logic home_req = 1'b0;
    logic abort = 1'b0;
    logic enc_a = 1'b1;
    logic enc_b = 1'b1;
    logic enc_i = 1'b0;
    logic home;
    logic busy;
    logic homed;
    logic timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int home_cnt = 0;

    enc_home_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_W      (8),
        .IDX_MIN        (4),
        .GATE_AB        (1'b1)
    ) dut (
        .sclk        (sclk),
        .rstn        (rstn),
        .home_req    (home_req),
        .abort       (abort),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .enc_i       (enc_i),
        .home        (home),
        .busy        (busy),
        .homed       (homed),
        .timeout_err (timeout_err)
    );

    always #5 sclk = ~sclk;

    // Counts strobe cycles, sampled mid-cycle.
    always @(negedge sclk) begin
        if (home === 1'b1) home_cnt = home_cnt + 1;
    end

    typedef struct {
        logic       req;
        logic       abt;
        logic       a;
        logic       b;
        logic       i;
        logic [3:0] exp; // {home, busy, homed, timeout_err}
    } vec_t;

    vec_t vecs [16];

    function automatic logic [3:0] obs();
        return {home, busy, homed, timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, return just after it.
    task automatic step(input logic req, input logic abt, input logic a, input logic b, input logic i);
        @(negedge sclk);
        home_req = req;
        abort    = abt;
        enc_a    = a;
        enc_b    = b;
        enc_i    = i;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n, input logic i);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b1, i);
    endtask

    initial begin
        int h0;

        // Basic home: index rises in the cycle after the FSM enters SEEK,
        // held 10 cycles; req in SEEK (vector 6) must be ignored.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010};

        repeat (2) @(posedge sclk);
        #1;
        check("reset_outputs", 32'(obs()), 32'h0);
        @(negedge sclk);
        rstn = 1'b1;

        for (int v = 0; v < 16; v++) begin
            step(vecs[v].req, vecs[v].abt, vecs[v].a, vecs[v].b, vecs[v].i);
            check($sformatf("vec%0d", v), 32'(obs()), 32'(vecs[v].exp));
        end
        check("basic_single_strobe", home_cnt, 1);

        // Index already high at request: ARM must wait for it to drop.
        idle(3, 1'b1);
        h0 = home_cnt;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(5, 1'b1);
        check("held_busy", 32'(busy), 32'h1);
        check("held_no_home", home_cnt - h0, 0);
        idle(3, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            check($sformatf("held_rise_home_k%0d", k), 32'(home), 32'(k == 6));
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("held_done", 32'(obs()), 32'b0010);

        // 3-cycle pulse and an A=0 pulse must not qualify; next 5-cycle pulse homes.
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        h0 = home_cnt;
        idle(3, 1'b1);
        idle(5, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b0);
        check("short_gated_no_home", home_cnt - h0, 0);
        check("short_gated_busy", 32'(obs()), 32'b0100);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, k <= 5);
            check($sformatf("pulse5_home_k%0d", k), 32'(home), 32'(k == 6));
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pulse5_done", 32'(obs()), 32'b0010);

        // abort together with home_req in IDLE: nothing starts, flags kept.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_req_idle", 32'(obs()), 32'b0010);
        idle(1, 1'b0);
        check("abort_req_idle_next", 32'(obs()), 32'b0010);

        // Timeout: ERR exactly TMO cycles after ARM, flag one cycle later.
        h0 = home_cnt;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("tmo_start", 32'(obs()), 32'b0100);
        idle(TMO - 1, 1'b0);
        check("tmo_before", 32'(obs()), 32'b0100);
        idle(1, 1'b0);
        check("tmo_err_state", 32'(obs()), 32'b0000);
        idle(1, 1'b0);
        check("tmo_flag", 32'(obs()), 32'b0001);
        idle(2, 1'b0);
        check("tmo_sticky", 32'(obs()), 32'b0001);
        check("tmo_no_home", home_cnt - h0, 0);

        // New request clears timeout_err; abort in SEEK returns to IDLE quietly.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("req_clears_tmo", 32'(obs()), 32'b0100);
        idle(1, 1'b0);
        h0 = home_cnt;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_seek", 32'(obs()), 32'b0000);
        idle(6, 1'b1);
        idle(2, 1'b0);
        check("abort_no_home", home_cnt - h0, 0);
        check("abort_flags", 32'(obs()), 32'b0000);

        // Reset mid-SEEK while a qualifying pulse is building.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        h0 = home_cnt;
        idle(3, 1'b1);
        check("pre_reset_busy", 32'(busy), 32'h1);
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs()), 32'b0000);
        @(negedge sclk);
        enc_i = 1'b0;
        @(negedge sclk);
        rstn = 1'b1;
        idle(4, 1'b0);
        check("reset_no_home", home_cnt - h0, 0);
        check("post_reset_idle", 32'(obs()), 32'b0000);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            check($sformatf("post_reset_home_k%0d", k), 32'(home), 32'(k == 6));
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_reset_done", 32'(obs()), 32'b0010);
        check("post_reset_one_strobe", home_cnt - h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enc_home_ctrl.md
# enc_home_ctrl

Homing sequencer for one quadrature encoder channel. On software request it arms, waits for a qualified index pulse, then issues a single-cycle `home` strobe to the encoder counter so the count is zeroed at the mechanical index. It reports busy, homed and timeout status to the rover motor-control register block, and sits between that block and the encoder counter's `home` input.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100_000_000: maximum cycles spent in ARM+SEEK before error (1 s at 100 MHz).
- `TIMEOUT_W`, default 27: timeout counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- `IDX_MIN`, default 4: consecutive synchronized cycles the index must be high to qualify (1..15).
- `GATE_AB`, default 1: when 1, the index only qualifies while synchronized A and B are both high.

Ports:
- `sclk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `home_req` in 1: single-cycle start request.
- `abort` in 1: cancel the sequence in progress.
- `enc_a`, `enc_b`, `enc_i` in 1 each: raw encoder pins (asynchronous).
- `home` out 1: one-cycle zero strobe to the encoder counter.
- `busy` out 1: high in ARM, SEEK and HOME.
- `homed` out 1: sticky; set on a successful home.
- `timeout_err` out 1: sticky; set on timeout.

## Operation
- Inputs `enc_a`, `enc_b` and `enc_i` pass through 2-flop synchronizers. `idx_q` is the synchronized index ANDed with (A&B when GATE_AB=1).
- The qualification counter (4 bits) counts consecutive `idx_q` cycles, saturates at IDX_MIN, and clears when `idx_q` is low. `idx_ok` = (count == IDX_MIN).
- FSM states:
  - IDLE: waits for `home_req`.
    - On `home_req`: clear `homed` and `timeout_err`, clear the timeout counter, go to ARM.
  - ARM: waits for `idx_q` low, so a pulse already in progress is never used.
    - When `idx_q` is low, go to SEEK.
  - SEEK: waits for `idx_ok`.
    - When `idx_ok` is high, go to HOME.
  - HOME: `home`=1 for exactly this one cycle, `homed` is set, then go to IDLE.
  - ERR: `timeout_err` is set on entry; go to IDLE on the next cycle.
- The timeout counter increments every cycle in ARM and SEEK. When it reaches TIMEOUT_CYCLES-1 while still in ARM/SEEK, the FSM goes to ERR and no `home` is issued.
- `abort` in ARM or SEEK returns the FSM to IDLE next cycle: no `home` strobe, `homed` stays 0, `timeout_err` stays 0.
  - `abort` in HOME has no effect; the strobe completes.
- Simultaneous events:
  - `abort` and `home_req` in IDLE: abort wins; the FSM stays in IDLE and flags are not cleared.
  - Timeout and `idx_ok` on the same cycle: `idx_ok` wins and the FSM goes to HOME.
- `home_req` outside IDLE is ignored, not queued.
- Reset values: state=IDLE, `home`=0, `busy`=0, `homed`=0, `timeout_err`=0, synchronizers and counters all 0.
- Reset mid-sequence returns to IDLE asynchronously and no strobe is emitted.

## Timing
- Raw index rise to `idx_q`: 2 cycles (synchronizer).
- `idx_q` rise to `idx_ok`: IDX_MIN-1 further cycles, counting the first qualifying cycle as count 1.
- `idx_ok` to `home` high: 1 cycle (HOME state; `home` is a registered output).
- Raw index rise to `home`: 2+IDX_MIN cycles (6 with defaults), provided the FSM is already in SEEK.
- `home_req` to `busy`: 1 cycle. `busy` falls in the cycle after HOME, together with `homed` going visible-high.
- All outputs are registered. `home` is never high for more than one cycle per request.
- Timeout: ERR is entered exactly TIMEOUT_CYCLES cycles after entering ARM; `timeout_err` goes high one cycle later.

## Structure
- Shared package `enc_pkg`:
  - `home_state_t` enum (IDLE, ARM, SEEK, HOME, ERR).
  - Constant `IDX_CNT_W` = 4.
- Sub-module `idx_qualifier`: contains the synchronizers, the A/B gate and the qualification counter. Outputs `idx_q` and `idx_ok`. It is reusable by a future index-error monitor.
- Top level holds the FSM, the timeout counter and the status flags.

## Test plan
- Reset released, index idle, `home_req` pulse, then raw index high for 10 cycles with A=B=1 → `home` high for one cycle, 6 cycles after the index rise; `homed`=1, `busy`=0 afterwards.
- Index held high when `home_req` arrives → no `home` until the index drops and rises again; the strobe follows the second rising edge.
- Index pulse 3 cycles wide (IDX_MIN=4), or A=0 with GATE_AB=1 → no `home`; the next valid 5-cycle pulse homes.
- TIMEOUT_CYCLES=50 with no index → ERR entered 50 cycles after ARM, `timeout_err`=1, `homed`=0, `home` never high. A subsequent `home_req` clears `timeout_err`.
- `abort` during SEEK → IDLE next cycle, no `home`, both flags 0. `abort` and `home_req` together in IDLE → stays IDLE.
- `rstn` asserted low mid-SEEK → all outputs 0 immediately. After release, `home_req` runs a normal sequence.
